// File: rtl/etc_rgb_pixel_pipe_pkg.sv
// Shared types and constants for the ETC1/ETC2 pixel pipe: FSM states, the
// modifier magnitude table, index-to-column mapping and RGBA lane packing.
package etc_rgb_pixel_pipe_pkg;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  // Row t of the modifier table is (-large, -small, +small, +large).
  localparam logic [7:0] MOD_SMALL [8] = '{8'd2, 8'd5, 8'd9, 8'd13, 8'd18, 8'd24, 8'd33, 8'd47};
  localparam logic [7:0] MOD_LARGE [8] = '{8'd8, 8'd17, 8'd29, 8'd42, 8'd60, 8'd80, 8'd106, 8'd183};
  localparam logic [1:0] IDX_TO_COL [4] = '{2'd2, 2'd3, 2'd1, 2'd0};

  localparam int RGBA_W = 32;

  function automatic int lane_lsb(input int k);
    return RGBA_W * k;
  endfunction

  function automatic logic signed [9:0] col_modifier(input logic [2:0] t, input logic [1:0] col);
    logic signed [9:0] small_v;
    logic signed [9:0] large_v;
    small_v = signed'({2'b00, MOD_SMALL[t]});
    large_v = signed'({2'b00, MOD_LARGE[t]});
    case (col)
      2'd0:    return -large_v;
      2'd1:    return -small_v;
      2'd2:    return small_v;
      default: return large_v;
    endcase
  endfunction

endpackage

// File: rtl/etc_rgb_pixel_pipe_if.sv
// Block-descriptor input and texel-beat output handshakes of the pixel pipe.
interface etc_rgb_pixel_pipe_if #(parameter int LANES = 2);
  logic                  in_valid;
  logic                  in_ready;
  logic [63:0]           in_block;
  logic [23:0]           in_base0;
  logic [23:0]           in_base1;
  logic                  in_flipped;
  logic                  in_punch;
  logic                  in_opaque;
  logic                  out_valid;
  logic                  out_ready;
  logic [32*LANES-1:0]   out_rgba;
  logic [3:0]            out_pix_idx;
  logic                  out_last;

  modport master (
    output in_valid, in_block, in_base0, in_base1, in_flipped, in_punch, in_opaque, out_ready,
    input  in_ready, out_valid, out_rgba, out_pix_idx, out_last
  );

  modport slave (
    input  in_valid, in_block, in_base0, in_base1, in_flipped, in_punch, in_opaque, out_ready,
    output in_ready, out_valid, out_rgba, out_pix_idx, out_last
  );
endinterface

// File: rtl/etc_rgb_pixel_pipe_texel_lane.sv
// One texel lane: index/sub-block/modifier selection feeding stage 1, and
// the add-and-clamp of the registered stage-1 values feeding stage 2.
module etc_texel_lane
  import etc_rgb_pixel_pipe_pkg::*;
(
  input  logic [31:0]        i_idx_bits,
  input  logic [2:0]         i_tbl0,
  input  logic [2:0]         i_tbl1,
  input  logic [23:0]        i_base0,
  input  logic [23:0]        i_base1,
  input  logic               i_flipped,
  input  logic               i_punch_mode,
  input  logic [3:0]         i_pix,
  output logic signed [9:0]  o_mod,
  output logic [23:0]        o_base,
  output logic               o_transp,
  input  logic signed [9:0]  i_s1_mod,
  input  logic [23:0]        i_s1_base,
  input  logic               i_s1_transp,
  output logic [31:0]        o_rgba
);

  logic [1:0] w_idx;
  logic       w_sub;
  logic [2:0] w_tbl;

  function automatic logic [7:0] clamp8(input logic [7:0] ch, input logic signed [9:0] m);
    logic signed [9:0] s;
    s = signed'({2'b00, ch}) + m;
    if (s < 0)           return 8'd0;
    if (s > 10'sd255)    return 8'hFF;
    return s[7:0];
  endfunction

  // Texels are column-major, so p[1] marks the bottom half and p[3] the right half.
  assign w_idx = {i_idx_bits[{1'b1, i_pix}], i_idx_bits[{1'b0, i_pix}]};
  assign w_sub = i_flipped ? i_pix[1] : i_pix[3];
  assign w_tbl = w_sub ? i_tbl1 : i_tbl0;

  always_comb begin
    o_base   = w_sub ? i_base1 : i_base0;
    o_transp = i_punch_mode && (w_idx == 2'b10);
    o_mod    = col_modifier(w_tbl, IDX_TO_COL[w_idx]);
    if (i_punch_mode && (w_idx == 2'b00)) o_mod = '0;
  end

  always_comb begin
    o_rgba = {8'hFF, clamp8(i_s1_base[23:16], i_s1_mod),
                     clamp8(i_s1_base[15:8],  i_s1_mod),
                     clamp8(i_s1_base[7:0],   i_s1_mod)};
    if (i_s1_transp) o_rgba = '0;
  end

endmodule

// File: rtl/etc_rgb_pixel_pipe.sv
// ETC1/ETC2 individual/differential pixel pipe: holds one 4x4 block and streams
// its 16 texels as LANES-wide beats through a two-stage stallable pipeline.
//
//   state   | meaning
//   IDLE    | no block held; in_ready high, waiting for a descriptor
//   RUN     | issuing beats of the held block; reloads on the last beat
module etc_rgb_pixel_pipe
  import etc_rgb_pixel_pipe_pkg::*;
#(
  parameter int LANES    = 2,
  parameter bit ALPHA_EN = 1'b1
) (
  input  logic                 sclk,
  input  logic                 rsrt_n,
  etc_rgb_pixel_pipe_if.slave  bus
);

  localparam int         BEATS     = 16 / LANES;
  localparam int         SH        = $clog2(LANES);
  localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);

  state_t      r_state, w_state_nx;
  logic [3:0]  r_beat, w_beat_nx;
  logic        w_in_ready, w_load, w_adv, w_last;
  logic [3:0]  w_pix;

  logic [31:0] r_idx_bits;
  logic [2:0]  r_tbl0, r_tbl1;
  logic [23:0] r_base0, r_base1;
  logic        r_flipped, r_punch_mode;

  logic               r_s1_v, r_s1_last;
  logic [3:0]         r_s1_pix;
  logic signed [9:0]  r_s1_mod   [LANES];
  logic [23:0]        r_s1_base  [LANES];
  logic               r_s1_transp[LANES];

  logic                r_s2_v, r_s2_last;
  logic [3:0]          r_s2_pix;
  logic [32*LANES-1:0] r_s2_rgba;

  logic signed [9:0]   w_mod      [LANES];
  logic [23:0]         w_base     [LANES];
  logic                w_transp   [LANES];
  logic [31:0]         w_lane_rgba[LANES];
  logic [32*LANES-1:0] w_rgba;
  logic                w_unused_blk;

  assign w_unused_blk = ^{bus.in_block[63:40], bus.in_block[33:32]};

  assign w_adv  = !r_s2_v || bus.out_ready;
  assign w_last = (r_beat == LAST_BEAT);
  assign w_pix  = r_beat << SH;

  always_comb begin
    w_state_nx = r_state;
    w_beat_nx  = r_beat;
    w_in_ready = 1'b0;
    w_load     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_load     = 1'b1;
          w_beat_nx  = '0;
          w_state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_adv) begin
          if (w_last) begin
            w_in_ready = 1'b1;
            w_beat_nx  = '0;
            if (bus.in_valid) w_load = 1'b1;
            else              w_state_nx = ST_IDLE;
          end else begin
            w_beat_nx = r_beat + 4'd1;
          end
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge rsrt_n) begin
    if (!rsrt_n) begin
      r_state      <= ST_IDLE;
      r_beat       <= '0;
      r_idx_bits   <= '0;
      r_tbl0       <= '0;
      r_tbl1       <= '0;
      r_base0      <= '0;
      r_base1      <= '0;
      r_flipped    <= 1'b0;
      r_punch_mode <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_beat  <= w_beat_nx;
      if (w_load) begin
        r_idx_bits   <= bus.in_block[31:0];
        r_tbl0       <= bus.in_block[39:37];
        r_tbl1       <= bus.in_block[36:34];
        r_base0      <= bus.in_base0;
        r_base1      <= bus.in_base1;
        r_flipped    <= bus.in_flipped;
        r_punch_mode <= bus.in_punch && !bus.in_opaque && ALPHA_EN;
      end
    end
  end

  genvar k;
  generate
    for (k = 0; k < LANES; k++) begin : g_lane
      etc_texel_lane u_lane (
        .i_idx_bits  (r_idx_bits),
        .i_tbl0      (r_tbl0),
        .i_tbl1      (r_tbl1),
        .i_base0     (r_base0),
        .i_base1     (r_base1),
        .i_flipped   (r_flipped),
        .i_punch_mode(r_punch_mode),
        .i_pix       (w_pix + 4'(k)),
        .o_mod       (w_mod[k]),
        .o_base      (w_base[k]),
        .o_transp    (w_transp[k]),
        .i_s1_mod    (r_s1_mod[k]),
        .i_s1_base   (r_s1_base[k]),
        .i_s1_transp (r_s1_transp[k]),
        .o_rgba      (w_lane_rgba[k])
      );
    end
  endgenerate

  always_comb begin
    w_rgba = '0;
    for (int i = 0; i < LANES; i++) w_rgba[lane_lsb(i) +: RGBA_W] = w_lane_rgba[i];
  end

  // Stage 1 and stage 2 move together so a stall never drops or repeats a beat.
  always_ff @(posedge sclk or negedge rsrt_n) begin
    if (!rsrt_n) begin
      r_s1_v    <= 1'b0;
      r_s1_last <= 1'b0;
      r_s1_pix  <= '0;
      for (int i = 0; i < LANES; i++) begin
        r_s1_mod[i]    <= '0;
        r_s1_base[i]   <= '0;
        r_s1_transp[i] <= 1'b0;
      end
      r_s2_v    <= 1'b0;
      r_s2_last <= 1'b0;
      r_s2_pix  <= '0;
      r_s2_rgba <= '0;
    end else if (w_adv) begin
      r_s1_v    <= (r_state == ST_RUN);
      r_s1_last <= w_last;
      r_s1_pix  <= w_pix;
      for (int i = 0; i < LANES; i++) begin
        r_s1_mod[i]    <= w_mod[i];
        r_s1_base[i]   <= w_base[i];
        r_s1_transp[i] <= w_transp[i];
      end
      r_s2_v    <= r_s1_v;
      r_s2_last <= r_s1_v && r_s1_last;
      r_s2_pix  <= r_s1_pix;
      r_s2_rgba <= w_rgba;
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.out_valid   = r_s2_v;
  assign bus.out_last    = r_s2_last;
  assign bus.out_pix_idx = r_s2_pix;
  assign bus.out_rgba    = r_s2_rgba;

endmodule

// File: tb/tb_etc_rgb_pixel_pipe.sv
// Bench for etc_rgb_pixel_pipe: hand-computed vector table plus a reference
// model scoreboard, with ALPHA_EN=1 and ALPHA_EN=0 instances run in lockstep.
module tb_etc_rgb_pixel_pipe;

  localparam int LANES = 2;
  localparam int BEATS = 16 / LANES;
  localparam int NV    = 10;

  logic sclk   = 1'b0;
  logic rsrt_n = 1'b0;
  always #5 sclk = ~sclk;

  etc_rgb_pixel_pipe_if #(.LANES(LANES)) b0 ();
  etc_rgb_pixel_pipe_if #(.LANES(LANES)) b1 ();

  assign b1.in_valid   = b0.in_valid;
  assign b1.in_block   = b0.in_block;
  assign b1.in_base0   = b0.in_base0;
  assign b1.in_base1   = b0.in_base1;
  assign b1.in_flipped = b0.in_flipped;
  assign b1.in_punch   = b0.in_punch;
  assign b1.in_opaque  = b0.in_opaque;
  assign b1.out_ready  = b0.out_ready;

  etc_rgb_pixel_pipe #(.LANES(LANES), .ALPHA_EN(1'b1)) u_dut_a1 (.sclk(sclk), .rsrt_n(rsrt_n), .bus(b0));
  etc_rgb_pixel_pipe #(.LANES(LANES), .ALPHA_EN(1'b0)) u_dut_a0 (.sclk(sclk), .rsrt_n(rsrt_n), .bus(b1));

  typedef struct {
    logic [63:0] blk;
    logic [23:0] base0;
    logic [23:0] base1;
    logic        flipped;
    logic        punch;
    logic        opaque;
    int          chk_p;
    logic [31:0] exp_a1;
    logic [31:0] exp_a0;
  } vec_t;

  typedef struct {
    logic [63:0] rgba1;
    logic [63:0] rgba0;
    logic [3:0]  pix;
    logic        last;
    int          blk;
  } exp_t;

  vec_t        vecs [NV];
  exp_t        q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          blk_id = 0;
  int          hand_p [64];
  logic [31:0] hand_a1 [64];
  logic [31:0] hand_a0 [64];
  bit          rdy_rand = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] clamp_ch(input int v);
    if (v < 0)   return 8'd0;
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  function automatic logic [31:0] model(input vec_t d, input bit aen, input int p);
    logic [1:0]  idx;
    bit          sub, tr;
    int          t, sm, lg, m;
    logic [23:0] base;
    idx = {d.blk[p+16], d.blk[p]};
    sub = d.flipped ? ((p % 4) >= 2) : (p >= 8);
    t   = sub ? int'(d.blk[36:34]) : int'(d.blk[39:37]);
    case (t)
      0: begin sm = 2;  lg = 8;   end
      1: begin sm = 5;  lg = 17;  end
      2: begin sm = 9;  lg = 29;  end
      3: begin sm = 13; lg = 42;  end
      4: begin sm = 18; lg = 60;  end
      5: begin sm = 24; lg = 80;  end
      6: begin sm = 33; lg = 106; end
      default: begin sm = 47; lg = 183; end
    endcase
    case (idx)
      2'b00: m = sm;
      2'b01: m = lg;
      2'b10: m = -sm;
      default: m = -lg;
    endcase
    tr = d.punch && !d.opaque && aen;
    if (tr && idx == 2'b10) return 32'h0;
    if (tr && idx == 2'b00) m = 0;
    base = sub ? d.base1 : d.base0;
    return {8'hFF, clamp_ch(int'(base[23:16]) + m), clamp_ch(int'(base[15:8]) + m),
            clamp_ch(int'(base[7:0]) + m)};
  endfunction

  task automatic send(input vec_t v);
    int   w;
    exp_t e;
    b0.in_block   = v.blk;
    b0.in_base0   = v.base0;
    b0.in_base1   = v.base1;
    b0.in_flipped = v.flipped;
    b0.in_punch   = v.punch;
    b0.in_opaque  = v.opaque;
    b0.in_valid   = 1'b1;
    w = 0;
    @(negedge sclk);
    while (!b0.in_ready && w < 300) begin
      w++;
      @(negedge sclk);
    end
    if (!b0.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready stayed %b, required 1", b0.in_ready);
    end else begin
      hand_p[blk_id]  = v.chk_p;
      hand_a1[blk_id] = v.exp_a1;
      hand_a0[blk_id] = v.exp_a0;
      for (int b = 0; b < BEATS; b++) begin
        e.rgba1 = {model(v, 1'b1, 2*b+1), model(v, 1'b1, 2*b)};
        e.rgba0 = {model(v, 1'b0, 2*b+1), model(v, 1'b0, 2*b)};
        e.pix   = 4'(2*b);
        e.last  = (b == BEATS-1);
        e.blk   = blk_id;
        q.push_back(e);
      end
      blk_id++;
    end
    @(posedge sclk);
    #1;
    b0.in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while ((q.size() != 0 || b0.out_valid) && w < 3000) begin
      @(posedge sclk);
      #1;
      w++;
    end
    check(name, 64'(q.size()), 64'd0);
  endtask

  initial begin
    forever begin
      @(posedge sclk);
      #1;
      b0.out_ready = rdy_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Scoreboard pop and stall-stability monitor.
  logic        st_flag = 1'b0;
  logic [63:0] st_rgba;
  logic [3:0]  st_pix;
  logic        st_last;
  always @(negedge sclk) begin
    exp_t e;
    if (!rsrt_n) begin
      st_flag = 1'b0;
    end else begin
      if (st_flag) begin
        check("stall_valid", b0.out_valid, 1'b1);
        check("stall_rgba", b0.out_rgba, st_rgba);
        check("stall_pix", b0.out_pix_idx, st_pix);
        check("stall_last", b0.out_last, st_last);
      end
      if (b0.out_valid && b0.out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: pix %0d with empty scoreboard", b0.out_pix_idx);
        end else begin
          e = q.pop_front();
          check("rgba_alpha_en1", b0.out_rgba, e.rgba1);
          check("rgba_alpha_en0", b1.out_rgba, e.rgba0);
          check("pix_idx", b0.out_pix_idx, e.pix);
          check("last", b0.out_last, e.last);
          check("dut_a0_valid", b1.out_valid, 1'b1);
          for (int k = 0; k < LANES; k++) begin
            if (hand_p[e.blk] == int'(e.pix) + k) begin
              check("hand_alpha_en1", b0.out_rgba[32*k +: 32], hand_a1[e.blk]);
              check("hand_alpha_en0", b1.out_rgba[32*k +: 32], hand_a0[e.blk]);
            end
          end
        end
      end
      st_flag = b0.out_valid && !b0.out_ready;
      st_rgba = b0.out_rgba;
      st_pix  = b0.out_pix_idx;
      st_last = b0.out_last;
    end
  end

  initial begin
    vec_t rv;
    int   w;
    //          blk                                base0        base1        fl    pu    op    p  exp a1         exp a0
    vecs[0] = '{64'h0,                             24'h003264, 24'h003264, 1'b0, 1'b0, 1'b0, 5, 32'hFF023466, 32'hFF023466};
    vecs[1] = '{(64'd7 << 37) | 64'd1,             24'h0000FA, 24'h000000, 1'b0, 1'b0, 1'b0, 0, 32'hFFB7B7FF, 32'hFFB7B7FF};
    vecs[2] = '{(64'd7 << 37) | (64'd1 << 16) | 64'd1, 24'h64C80A, 24'h000000, 1'b0, 1'b0, 1'b0, 0, 32'hFF001100, 32'hFF001100};
    vecs[3] = '{64'h0,                             24'h000064, 24'h0000C8, 1'b1, 1'b0, 1'b0, 2, 32'hFF0202CA, 32'hFF0202CA};
    vecs[4] = '{64'h0,                             24'h000064, 24'h0000C8, 1'b0, 1'b0, 1'b0, 8, 32'hFF0202CA, 32'hFF0202CA};
    vecs[5] = '{64'h0,                             24'h000064, 24'h0000C8, 1'b1, 1'b0, 1'b0, 4, 32'hFF020266, 32'hFF020266};
    vecs[6] = '{64'd1 << 16,                       24'h000064, 24'h000000, 1'b0, 1'b1, 1'b0, 0, 32'h00000000, 32'hFF000062};
    vecs[7] = '{64'h0,                             24'h646464, 24'h000000, 1'b0, 1'b1, 1'b0, 0, 32'hFF646464, 32'hFF666666};
    vecs[8] = '{64'h0,                             24'h646464, 24'h000000, 1'b0, 1'b1, 1'b1, 0, 32'hFF666666, 32'hFF666666};
    vecs[9] = '{(64'd3 << 34) | (64'd1 << 25),     24'h000000, 24'h808080, 1'b0, 1'b0, 1'b0, 9, 32'hFF737373, 32'hFF737373};

    b0.in_valid = 1'b0; b0.in_block = '0; b0.in_base0 = '0; b0.in_base1 = '0;
    b0.in_flipped = 1'b0; b0.in_punch = 1'b0; b0.in_opaque = 1'b0; b0.out_ready = 1'b1;

    repeat (3) @(posedge sclk);
    #1;
    check("rst_out_valid", b0.out_valid, 1'b0);
    check("rst_out_last", b0.out_last, 1'b0);
    check("rst_out_rgba", b0.out_rgba, 64'h0);
    check("rst_out_pix", b0.out_pix_idx, 4'd0);
    rsrt_n = 1'b1;
    #1;
    check("rst_in_ready", b0.in_ready, 1'b1);

    send(vecs[0]);
    @(posedge sclk); #1;
    check("latency_edge1_valid", b0.out_valid, 1'b0);
    @(posedge sclk); #1;
    check("latency_edge2_valid", b0.out_valid, 1'b1);

    for (int i = 1; i < NV; i++) send(vecs[i]);
    drain("drain_table");

    rdy_rand = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rv.blk     = {$urandom, $urandom};
      rv.base0   = 24'($urandom);
      rv.base1   = 24'($urandom);
      rv.flipped = 1'($urandom_range(0, 1));
      rv.punch   = 1'($urandom_range(0, 1));
      rv.opaque  = 1'($urandom_range(0, 1));
      rv.chk_p   = -1;
      rv.exp_a1  = '0;
      rv.exp_a0  = '0;
      send(rv);
    end
    drain("drain_random");
    rdy_rand = 1'b0;
    repeat (2) @(posedge sclk);
    #1;

    send(vecs[7]);
    w = 0;
    while (!(b0.out_valid && b0.out_pix_idx == 4'd4) && w < 50) begin
      @(posedge sclk); #1;
      w++;
    end
    check("reach_beat3", b0.out_pix_idx, 4'd4);
    rsrt_n = 1'b0;
    #1;
    check("midrst_valid", b0.out_valid, 1'b0);
    check("midrst_rgba", b0.out_rgba, 64'h0);
    check("midrst_pix", b0.out_pix_idx, 4'd0);
    check("midrst_last", b0.out_last, 1'b0);
    check("midrst_valid_a0", b1.out_valid, 1'b0);
    q.delete();
    repeat (2) @(posedge sclk);
    #1;
    rsrt_n = 1'b1;
    #1;
    check("postrst_in_ready", b0.in_ready, 1'b1);
    send(vecs[1]);
    drain("drain_after_reset");
    check("final_idle_valid", b0.out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
